// File: rtl/pixel_pkg.sv
// rtl/pixel_pkg.sv - shared types and sizing helpers for the pixel array frame controller
package pixel_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ERASE_S,
        EXPOSE_S,
        CONV_S,
        ROW_LOAD,
        STREAM
    } state_t;

    localparam int DEF_N_ROWS       = 2;
    localparam int DEF_N_COLS       = 2;
    localparam int DEF_ADC_BITS     = 8;
    localparam int DEF_ERASE_CYCLES = 5;
    localparam int DEF_EXP_W        = 16;

    // Width of a counter holding 0..n-1; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pixel_row_serializer.sv
// rtl/pixel_row_serializer.sv - buffers one pixel row and streams it out one column per beat
module pixel_row_serializer
    import pixel_pkg::*;
#(
    parameter int N_COLS   = DEF_N_COLS,
    parameter int ADC_BITS = DEF_ADC_BITS
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_load,
    input  logic [N_COLS*ADC_BITS-1:0]   i_pix_data,
    input  logic                         i_ready,
    output logic [ADC_BITS-1:0]          o_data,
    output logic                         o_valid,
    output logic                         o_line_end,
    output logic                         o_col_zero,
    output logic                         o_row_done
);

    localparam int COL_W = cnt_w(N_COLS);

    logic [N_COLS*ADC_BITS-1:0] r_buf;
    logic [COL_W-1:0]           r_col;
    logic                       r_valid;
    logic                       w_last;
    logic                       w_xfer;

    assign w_last = (r_col == COL_W'(N_COLS - 1));
    assign w_xfer = r_valid & i_ready;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_buf   <= '0;
            r_col   <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_buf   <= i_pix_data;
            r_col   <= '0;
            r_valid <= 1'b1;
        end else if (w_xfer) begin
            if (w_last) begin
                r_col   <= '0;
                r_valid <= 1'b0;
            end else begin
                r_col   <= r_col + COL_W'(1);
            end
        end
    end

    // Column index only moves on a transfer, so DATA and flags hold under backpressure.
    assign o_data     = r_buf[int'(r_col) * ADC_BITS +: ADC_BITS];
    assign o_valid    = r_valid;
    assign o_line_end = r_valid & w_last;
    assign o_col_zero = (r_col == '0);
    assign o_row_done = w_xfer & w_last;

endmodule

// File: rtl/pixel_array_ctrl.sv
// rtl/pixel_array_ctrl.sv - erase/expose/convert sequencer with row-by-row valid/ready readout
module pixel_array_ctrl
    import pixel_pkg::*;
#(
    parameter int N_ROWS       = DEF_N_ROWS,
    parameter int N_COLS       = DEF_N_COLS,
    parameter int ADC_BITS     = DEF_ADC_BITS,
    parameter int ERASE_CYCLES = DEF_ERASE_CYCLES,
    parameter int EXP_W        = DEF_EXP_W
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       START,
    input  logic                       CONTINUOUS,
    input  logic [EXP_W-1:0]           EXPOSE_TIME,
    output logic                       ERASE,
    output logic                       EXPOSE,
    output logic                       CONVERT,
    output logic [ADC_BITS-1:0]        CNT_VALUE,
    output logic [N_ROWS-1:0]          ROW_SEL,
    input  logic [N_COLS*ADC_BITS-1:0] PIX_DATA,
    output logic [ADC_BITS-1:0]        DATA,
    output logic                       DATA_VALID,
    input  logic                       DATA_READY,
    output logic                       FRAME_START,
    output logic                       LINE_END,
    output logic                       BUSY
);

    localparam int ROW_W = cnt_w(N_ROWS);
    localparam int ER_W  = cnt_w(ERASE_CYCLES);

    state_t               r_state;
    state_t               w_next;
    logic [ER_W-1:0]      r_erase_cnt;
    logic [EXP_W-1:0]     r_exp_cnt;
    logic [EXP_W-1:0]     r_exp_time;
    logic [ADC_BITS-1:0]  r_conv_cnt;
    logic [ROW_W-1:0]     r_row;

    logic w_erase_last;
    logic w_exp_last;
    logic w_conv_last;
    logic w_row_last;
    logic w_row_done;
    logic w_col_zero;
    logic w_frame_end;
    logic w_launch;
    logic w_load;

    assign w_erase_last = (r_erase_cnt == ER_W'(ERASE_CYCLES - 1));
    // A latched exposure of 0 behaves like 1: the first cycle is already the last.
    assign w_exp_last   = (r_exp_time <= EXP_W'(1)) || (r_exp_cnt == r_exp_time - EXP_W'(1));
    assign w_conv_last  = &r_conv_cnt;
    assign w_row_last   = (r_row == ROW_W'(N_ROWS - 1));
    assign w_frame_end  = (r_state == STREAM) && w_row_done && w_row_last;
    assign w_launch     = ((r_state == IDLE) && START) || (w_frame_end && CONTINUOUS);
    assign w_load       = (r_state == ROW_LOAD);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        ERASE   = 1'b0;
        EXPOSE  = 1'b0;
        CONVERT = 1'b0;
        BUSY    = 1'b1;
        ROW_SEL = '0;
        case (r_state)
            IDLE: begin
                BUSY = 1'b0;
                if (START) w_next = ERASE_S;
            end
            ERASE_S: begin
                ERASE = 1'b1;
                if (w_erase_last) w_next = EXPOSE_S;
            end
            EXPOSE_S: begin
                EXPOSE = 1'b1;
                if (w_exp_last) w_next = CONV_S;
            end
            CONV_S: begin
                CONVERT = 1'b1;
                if (w_conv_last) w_next = ROW_LOAD;
            end
            ROW_LOAD: begin
                ROW_SEL = N_ROWS'(1) << r_row;
                w_next  = STREAM;
            end
            STREAM: begin
                ROW_SEL = N_ROWS'(1) << r_row;
                if (w_row_done) begin
                    if (!w_row_last)     w_next = ROW_LOAD;
                    else if (CONTINUOUS) w_next = ERASE_S;
                    else                 w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Phase counters self-clear whenever their state is not active, so every entry starts at 0.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_erase_cnt <= '0;
            r_exp_cnt   <= '0;
            r_exp_time  <= '0;
            r_conv_cnt  <= '0;
            r_row       <= '0;
        end else begin
            if (w_launch) r_exp_time <= EXPOSE_TIME;
            r_erase_cnt <= ((r_state == ERASE_S) && !w_erase_last) ? r_erase_cnt + ER_W'(1) : '0;
            r_exp_cnt   <= ((r_state == EXPOSE_S) && !w_exp_last) ? r_exp_cnt + EXP_W'(1) : '0;
            r_conv_cnt  <= (r_state == CONV_S) ? r_conv_cnt + ADC_BITS'(1) : '0;
            if ((r_state == STREAM) && w_row_done) begin
                r_row <= w_row_last ? '0 : r_row + ROW_W'(1);
            end
        end
    end

    assign CNT_VALUE   = r_conv_cnt;
    assign FRAME_START = DATA_VALID && w_col_zero && (r_row == '0);

    pixel_row_serializer #(
        .N_COLS   (N_COLS),
        .ADC_BITS (ADC_BITS)
    ) u_ser (
        .i_clk      (CLK),
        .i_rst      (RESET),
        .i_load     (w_load),
        .i_pix_data (PIX_DATA),
        .i_ready    (DATA_READY),
        .o_data     (DATA),
        .o_valid    (DATA_VALID),
        .o_line_end (LINE_END),
        .o_col_zero (w_col_zero),
        .o_row_done (w_row_done)
    );

endmodule
